// File: rtl/word_reducer_pipelined.sv
// word_reducer_pipelined: folds WORD_COUNT words of WORD_WIDTH bits into one
// word with OR / AND / XOR through a registered binary tree of LEVELS stages.
// The whole pipeline advances together (global stall) under a valid/ready
// handshake, so no transaction is lost or duplicated.
// Optional feature: define WORD_REDUCER_MASK_EN to add the in_mask port, which
// substitutes the op identity for any word whose mask bit is clear.
module word_reducer_pipelined #(
    parameter int WORD_WIDTH = 36,
    parameter int WORD_COUNT = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [1:0]                       in_op,
    input  logic [WORD_WIDTH*WORD_COUNT-1:0] in,
`ifdef WORD_REDUCER_MASK_EN
    input  logic [WORD_COUNT-1:0]            in_mask,
`endif
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_WIDTH-1:0]            out,
    output logic [1:0]                       out_op
);

    localparam int LEVELS = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int PADDED = 1 << LEVELS;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    // Pairwise combine; the reserved op arrives with all-zero operands, so
    // folding it as OR keeps the result at zero all the way down the tree.
    function automatic logic [WORD_WIDTH-1:0] combine(
        input logic [1:0]            op,
        input logic [WORD_WIDTH-1:0] a,
        input logic [WORD_WIDTH-1:0] b
    );
        logic [WORD_WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            default: r = a | b;
        endcase
        return r;
    endfunction

    // Level 0 (combinational padded input words) followed by the registered
    // tree nodes, laid out level by level: level L starts at
    // 2*PADDED - 2*PADDED/2^L and holds PADDED/2^L words. The root is last.
    logic [PADDED-1:0][WORD_WIDTH-1:0]   pad_words;
    logic [PADDED-2:0][WORD_WIDTH-1:0]   node_reg;
    logic [PADDED-2:0][WORD_WIDTH-1:0]   node_next;
    logic [2*PADDED-2:0][WORD_WIDTH-1:0] tree;

    // Per-stage op and valid; index 0 of the *_src vectors is the input side.
    logic [LEVELS:1][1:0] op_reg;
    logic [LEVELS:1]      valid_reg;
    logic [LEVELS:0][1:0] op_src;
    logic [LEVELS:0]      valid_src;

    logic [WORD_WIDTH-1:0] identity_word;
    logic                  advance;

    assign identity_word = (in_op == OP_AND) ? '1 : '0;
    assign tree          = {node_reg, pad_words};
    assign op_src        = {op_reg, in_op};
    assign valid_src     = {valid_reg, in_valid};

    // Whole pipeline moves only when the output slot is empty or draining.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    assign out       = tree[2*PADDED-2];
    assign out_op    = op_src[LEVELS];
    assign out_valid = valid_src[LEVELS];

    genvar gi, gj;

    // Build level 0: real words (zeroed for the reserved op, identity when
    // masked off) followed by identity padding up to a power of two.
    for (gi = 0; gi < PADDED; gi++) begin : g_pad
        if (gi < WORD_COUNT) begin : g_word
`ifdef WORD_REDUCER_MASK_EN
            assign pad_words[gi] = (in_op == OP_RSV || !in_mask[gi]) ? identity_word
                                 : in[gi*WORD_WIDTH +: WORD_WIDTH];
`else
            assign pad_words[gi] = (in_op == OP_RSV) ? identity_word
                                 : in[gi*WORD_WIDTH +: WORD_WIDTH];
`endif
        end else begin : g_fill
            assign pad_words[gi] = identity_word;
        end
    end

    // Each tree level combines adjacent pairs of the level above it, using
    // the op that travels alongside that level's data.
    for (gi = 1; gi <= LEVELS; gi++) begin : g_level
        localparam int SRC_BASE = 2*PADDED - ((2*PADDED) >> (gi-1));
        localparam int DST_BASE = PADDED - ((2*PADDED) >> gi);
        localparam int NODES    = PADDED >> gi;
        for (gj = 0; gj < NODES; gj++) begin : g_node
            assign node_next[DST_BASE+gj] = combine(op_src[gi-1],
                                                    tree[SRC_BASE+2*gj],
                                                    tree[SRC_BASE+2*gj+1]);
        end
    end

    // Stage registers: cleared on reset, loaded together whenever the pipe advances.
    always_ff @(posedge clock) begin
        if (reset) begin
            node_reg  <= '0;
            op_reg    <= '0;
            valid_reg <= '0;
        end else if (advance) begin
            node_reg <= node_next;
            for (int l = 1; l <= LEVELS; l++) begin
                op_reg[l]    <= op_src[l-1];
                valid_reg[l] <= valid_src[l-1];
            end
        end
    end

endmodule

// File: tb/tb_word_reducer_pipelined.sv
// Directed and scoreboarded bench for word_reducer_pipelined: reset, streaming,
// backpressure, identity padding (3-word instance), reserved op and, when
// WORD_REDUCER_MASK_EN is defined, the word mask.
module tb_word_reducer_pipelined;

    localparam int W  = 36;
    localparam int C  = 4;
    localparam int C3 = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset;
    logic           in_valid, in_ready, out_valid, out_ready;
    logic [1:0]     in_op, out_op;
    logic [W*C-1:0] in_bus;
    logic [W-1:0]   out_word;
`ifdef WORD_REDUCER_MASK_EN
    logic [C-1:0]   in_mask;
    logic [C3-1:0]  in3_mask;
`endif

    logic            in3_valid, in3_ready, out3_valid, out3_ready;
    logic [1:0]      in3_op, out3_op;
    logic [W*C3-1:0] in3_bus;
    logic [W-1:0]    out3_word;

    word_reducer_pipelined #(.WORD_WIDTH(W), .WORD_COUNT(C)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in        (in_bus),
`ifdef WORD_REDUCER_MASK_EN
        .in_mask   (in_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_word),
        .out_op    (out_op)
    );

    word_reducer_pipelined #(.WORD_WIDTH(W), .WORD_COUNT(C3)) u_dut3 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in3_valid),
        .in_ready  (in3_ready),
        .in_op     (in3_op),
        .in        (in3_bus),
`ifdef WORD_REDUCER_MASK_EN
        .in_mask   (in3_mask),
`endif
        .out_valid (out3_valid),
        .out_ready (out3_ready),
        .out       (out3_word),
        .out_op    (out3_op)
    );

    int vec_count       = 0;
    int miscompare_count = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   op;
    } res_t;
    res_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompare_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W*C-1:0] pack4(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                             input logic [W-1:0] w2, input logic [W-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // Straight sequential fold used as the scoreboard reference.
    function automatic logic [W-1:0] ref_reduce(input logic [1:0] op, input logic [W*C-1:0] d,
                                                input logic [C-1:0] m);
        logic [W-1:0] acc;
        logic [W-1:0] w;
        if (op == 2'b11) return '0;
        acc = (op == 2'b01) ? '1 : '0;
        for (int k = 0; k < C; k++) begin
            if (m[k]) begin
                w = d[k*W +: W];
                case (op)
                    2'b00:   acc = acc | w;
                    2'b01:   acc = acc & w;
                    default: acc = acc ^ w;
                endcase
            end
        end
        return acc;
    endfunction

    task automatic score_cycle();
        logic [C-1:0] m;
        res_t e;
        m = '1;
`ifdef WORD_REDUCER_MASK_EN
        m = in_mask;
`endif
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("rand_unexpected_result", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rand_data", out_word, e.data);
                check("rand_op", out_op, e.op);
            end
        end
        if (in_valid && in_ready) begin
            e.data = ref_reduce(in_op, in_bus, m);
            e.op   = in_op;
            exp_q.push_back(e);
        end
        step();
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_op      = 2'b00;
        in_bus     = pack4(36'h123, 36'h456, 36'h789, 36'hABC);
        out_ready  = 1'b1;
        in3_valid  = 1'b0;
        in3_op     = 2'b00;
        in3_bus    = '0;
        out3_ready = 1'b1;
`ifdef WORD_REDUCER_MASK_EN
        in_mask    = '1;
        in3_mask   = '1;
`endif

        // Reset held 3 cycles with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_out_valid", out_valid, 1'b0);
            check("reset_out", out_word, 36'h0);
            check("reset_out_op", out_op, 2'b00);
            check("reset_in_ready", in_ready, 1'b1);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_reset_no_result", out_valid, 1'b0);
        end
        check("post_reset_in_ready", in_ready, 1'b1);

        // Streaming: three back-to-back transactions.
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_bus   = pack4(36'h1, 36'h2, 36'h4, 36'h8);
        step();
        check("stream_lat_valid", out_valid, 1'b0);
        in_op  = 2'b01;
        in_bus = pack4(36'hFF, 36'h0F, 36'h3F, 36'h1F);
        step();
        check("stream_or_valid", out_valid, 1'b1);
        check("stream_or", out_word, 36'hF);
        check("stream_or_op", out_op, 2'b00);
        in_op  = 2'b10;
        in_bus = pack4(36'h3, 36'h3, 36'h5, 36'h0);
        step();
        check("stream_and", out_word, 36'h0F);
        check("stream_and_op", out_op, 2'b01);
        in_valid = 1'b0;
        step();
        check("stream_xor", out_word, 36'h5);
        check("stream_xor_op", out_op, 2'b10);
        check("stream_xor_valid", out_valid, 1'b1);
        step();
        check("stream_idle_valid", out_valid, 1'b0);

        // Backpressure: result held for 5 cycles with out_ready low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_bus    = pack4(36'h10, 36'h20, 36'h40, 36'h80);
        step();
        in_op  = 2'b10;
        in_bus = pack4(36'hAA, 36'h55, 36'h0, 36'h0);
        step();
        check("bp_first_valid", out_valid, 1'b1);
        in_op  = 2'b01;
        in_bus = pack4(36'hF, 36'hF, 36'hF, 36'h7);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready_low", in_ready, 1'b0);
            step();
            check("bp_hold_out", out_word, 36'hF0);
            check("bp_hold_op", out_op, 2'b00);
            check("bp_hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1'b1);
        step();
        check("bp_second", out_word, 36'hFF);
        check("bp_second_op", out_op, 2'b10);
        in_valid = 1'b0;
        step();
        check("bp_third", out_word, 36'h7);
        check("bp_third_op", out_op, 2'b01);
        check("bp_third_valid", out_valid, 1'b1);
        step();
        check("bp_drained", out_valid, 1'b0);

        // Reserved op: zero result, op passed through, normal latency.
        in_valid = 1'b1;
        in_op    = 2'b11;
        in_bus   = pack4(36'hDEADBEEF1, 36'h123456789, 36'hFFFFFFFFF, 36'h5);
        step();
        in_valid = 1'b0;
        check("rsv_lat_valid", out_valid, 1'b0);
        step();
        check("rsv_valid", out_valid, 1'b1);
        check("rsv_out", out_word, 36'h0);
        check("rsv_op", out_op, 2'b11);
        step();

        // Padding on the 3-word instance.
        in3_valid = 1'b1;
        in3_op    = 2'b01;
        in3_bus   = {36'hF3, 36'hFF, 36'hF0};
        step();
        in3_op  = 2'b00;
        in3_bus = {36'h3, 36'h20, 36'h100};
        check("pad_lat_valid", out3_valid, 1'b0);
        step();
        in3_valid = 1'b0;
        check("pad_and", out3_word, 36'hF0);
        check("pad_and_op", out3_op, 2'b01);
        check("pad_and_valid", out3_valid, 1'b1);
        step();
        check("pad_or", out3_word, 36'h123);
        step();
        check("pad_idle", out3_valid, 1'b0);

`ifdef WORD_REDUCER_MASK_EN
        // Word mask.
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_bus   = pack4(36'h1, 36'h2, 36'h4, 36'h8);
        in_mask  = 4'b0101;
        step();
        in_op   = 2'b01;
        in_bus  = pack4(36'h0, 36'h0, 36'h0, 36'h0);
        in_mask = 4'b0000;
        step();
        in_valid = 1'b0;
        check("mask_or", out_word, 36'h5);
        step();
        check("mask_and_empty", out_word, 36'hFFFFFFFFF);
        check("mask_and_op", out_op, 2'b01);
        in_mask = '1;
        step();
`endif

        // Randomized valid/ready against the scoreboard.
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            for (int k = 0; k < C; k++)
                in_bus[k*W +: W] = {4'($urandom_range(0, 15)), 32'($urandom)};
`ifdef WORD_REDUCER_MASK_EN
            in_mask = 4'($urandom_range(0, 15));
`endif
            score_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) score_cycle();
        check("rand_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
